// File: rtl/cpu_control_sequencer.sv
// Microcode sequencer for the 8-bit CPU: T-state counter plus combinational control decode.
// Optional single-step gating is enabled by defining SINGLE_STEP_EN.
module cpu_control_sequencer #(
    parameter int         OP_W   = 4,
    parameter int         T_W    = 3,
    parameter logic [3:0] HLT_OP = 4'hF
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [OP_W-1:0] ir_op,
    input  logic            flag_c,
    input  logic            flag_z,
`ifdef SINGLE_STEP_EN
    input  logic            step_mode,
    input  logic            step,
`endif
    output logic [T_W-1:0]  tstate,
    output logic            halt,
    output logic            pc_oe,
    output logic            pc_inc,
    output logic            pc_we,
    output logic            mar_we,
    output logic            ram_oe,
    output logic            ram_we,
    output logic            ir_oe,
    output logic            ir_we,
    output logic            a_oe,
    output logic            a_we,
    output logic            b_we,
    output logic            alu_oe,
    output logic            alu_sub,
    output logic            flags_we,
    output logic            out_we
);

    typedef enum logic [T_W-1:0] {T0, T1, T2, T3, T4} tstate_t;

    tstate_t state_reg, state_next;
    logic    halt_reg;
    logic    halt_set;
    logic    last_step;
    logic    illegal;
    logic    adv;

`ifdef SINGLE_STEP_EN
    assign adv = !step_mode || step;
`else
    assign adv = 1'b1;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= T0;
            halt_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            halt_reg  <= halt_reg | halt_set;
        end
    end

    always_comb begin
        pc_oe = 1'b0; pc_inc = 1'b0; pc_we = 1'b0; mar_we = 1'b0;
        ram_oe = 1'b0; ram_we = 1'b0; ir_oe = 1'b0; ir_we = 1'b0;
        a_oe = 1'b0; a_we = 1'b0; b_we = 1'b0; alu_oe = 1'b0;
        alu_sub = 1'b0; flags_we = 1'b0; out_we = 1'b0;
        halt_set   = 1'b0;
        last_step  = 1'b0;
        illegal    = 1'b0;
        state_next = state_reg;

        // Controls are suppressed during reset and once halted, whatever tstate decodes to.
        if (rstn && !halt_reg) begin
            case (state_reg)
                T0: begin
                    pc_oe = 1'b1; mar_we = 1'b1;
                end
                T1: begin
                    ram_oe = 1'b1; ir_we = 1'b1; pc_inc = 1'b1;
                    case (ir_op)
                        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                        4'd7, 4'd8, 4'hE, 4'hF: last_step = 1'b0;
                        default:                 last_step = 1'b1;
                    endcase
                end
                T2: begin
                    if (ir_op == HLT_OP) begin
                        halt_set  = 1'b1;
                        last_step = 1'b1;
                    end else begin
                        case (ir_op)
                            4'd1, 4'd2, 4'd3, 4'd4: begin ir_oe = 1'b1; mar_we = 1'b1; end
                            4'd5: begin ir_oe = 1'b1; a_we = 1'b1; last_step = 1'b1; end
                            4'd6: begin ir_oe = 1'b1; pc_we = 1'b1; last_step = 1'b1; end
                            4'd7: begin ir_oe = 1'b1; pc_we = flag_c; last_step = 1'b1; end
                            4'd8: begin ir_oe = 1'b1; pc_we = flag_z; last_step = 1'b1; end
                            4'hE: begin a_oe = 1'b1; out_we = 1'b1; last_step = 1'b1; end
                            default: last_step = 1'b1;
                        endcase
                    end
                end
                T3: begin
                    case (ir_op)
                        4'd1:       begin ram_oe = 1'b1; a_we = 1'b1; last_step = 1'b1; end
                        4'd2, 4'd3: begin ram_oe = 1'b1; b_we = 1'b1; end
                        4'd4:       begin a_oe = 1'b1; ram_we = 1'b1; last_step = 1'b1; end
                        default:    last_step = 1'b1;
                    endcase
                end
                T4: begin
                    last_step = 1'b1;
                    if (ir_op == 4'd2 || ir_op == 4'd3) begin
                        alu_oe = 1'b1; a_we = 1'b1; flags_we = 1'b1;
                        alu_sub = (ir_op == 4'd3);
                    end
                end
                default: illegal = 1'b1;
            endcase
        end

        // Writes and the halt set only take effect in a cycle that actually advances.
        if (!adv) begin
            pc_inc = 1'b0; pc_we = 1'b0; mar_we = 1'b0; ram_we = 1'b0; ir_we = 1'b0;
            a_we = 1'b0; b_we = 1'b0; flags_we = 1'b0; out_we = 1'b0; halt_set = 1'b0;
        end

        if (halt_reg || illegal)
            state_next = T0;
        else if (adv)
            state_next = last_step ? T0 : tstate_t'(state_reg + 1'b1);
    end

    assign tstate = state_reg;
    assign halt   = halt_reg;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Self-checking bench for cpu_control_sequencer: per-cycle comparison against a
// table-driven instruction model plus directed literal checks.
module tb_cpu_control_sequencer;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] ir_op;
    logic       flag_c, flag_z;
    logic       step_mode = 1'b0;
    logic       step = 1'b0;
    logic [2:0] tstate;
    logic       halt;
    logic pc_oe, pc_inc, pc_we, mar_we, ram_oe, ram_we, ir_oe, ir_we;
    logic a_oe, a_we, b_we, alu_oe, alu_sub, flags_we, out_we;

    cpu_control_sequencer dut (
        .clk(clk), .rstn(rstn), .ir_op(ir_op), .flag_c(flag_c), .flag_z(flag_z),
`ifdef SINGLE_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .tstate(tstate), .halt(halt),
        .pc_oe(pc_oe), .pc_inc(pc_inc), .pc_we(pc_we), .mar_we(mar_we),
        .ram_oe(ram_oe), .ram_we(ram_we), .ir_oe(ir_oe), .ir_we(ir_we),
        .a_oe(a_oe), .a_we(a_we), .b_we(b_we), .alu_oe(alu_oe), .alu_sub(alu_sub),
        .flags_we(flags_we), .out_we(out_we)
    );

    always #5 clk = ~clk;

    localparam logic [14:0] PC_OE = 15'h4000, PC_INC = 15'h2000, PC_WE = 15'h1000,
        MAR_WE = 15'h0800, RAM_OE = 15'h0400, RAM_WE = 15'h0200, IR_OE = 15'h0100,
        IR_WE = 15'h0080, A_OE = 15'h0040, A_WE = 15'h0020, B_WE = 15'h0010,
        ALU_OE = 15'h0008, ALU_SUB = 15'h0004, FLAGS_WE = 15'h0002, OUT_WE = 15'h0001;
    localparam logic [14:0] OE_MASK = PC_OE | RAM_OE | IR_OE | A_OE | ALU_OE;
    localparam logic [14:0] WE_MASK = PC_INC | PC_WE | MAR_WE | RAM_WE | IR_WE |
                                      A_WE | B_WE | FLAGS_WE | OUT_WE;

    logic [14:0] ctrl;
    assign ctrl = {pc_oe, pc_inc, pc_we, mar_we, ram_oe, ram_we, ir_oe, ir_we,
                   a_oe, a_we, b_we, alu_oe, alu_sub, flags_we, out_we};

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Index of the final T-state of each instruction.
    function automatic int last_t(input logic [3:0] op);
        case (op)
            4'd0:                                     return 1;
            4'd1, 4'd4:                               return 3;
            4'd2, 4'd3:                               return 4;
            4'd5, 4'd6, 4'd7, 4'd8, 4'hE, 4'hF:       return 2;
            default:                                  return 1;
        endcase
    endfunction

    function automatic logic [14:0] exp_ctrl(input int t, input logic [3:0] op,
                                             input logic fc, input logic fz, input logic adv);
        logic [14:0] m;
        m = '0;
        if (t == 0)      m = PC_OE | MAR_WE;
        else if (t == 1) m = RAM_OE | IR_WE | PC_INC;
        else if (t <= last_t(op)) begin
            case (op)
                4'd1: m = (t == 2) ? (IR_OE | MAR_WE) : (RAM_OE | A_WE);
                4'd2, 4'd3:
                    if (t == 2)      m = IR_OE | MAR_WE;
                    else if (t == 3) m = RAM_OE | B_WE;
                    else             m = ALU_OE | A_WE | FLAGS_WE | ((op == 4'd3) ? ALU_SUB : 15'd0);
                4'd4: m = (t == 2) ? (IR_OE | MAR_WE) : (A_OE | RAM_WE);
                4'd5: m = IR_OE | A_WE;
                4'd6: m = IR_OE | PC_WE;
                4'd7: m = IR_OE | (fc ? PC_WE : 15'd0);
                4'd8: m = IR_OE | (fz ? PC_WE : 15'd0);
                4'hE: m = A_OE | OUT_WE;
                default: m = '0;
            endcase
        end
        if (!adv) m = m & ~WE_MASK;
        return m;
    endfunction

    logic tb_adv;
`ifdef SINGLE_STEP_EN
    assign tb_adv = !step_mode || step;
`else
    assign tb_adv = 1'b1;
`endif

    int m_t;
    bit m_halt;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_t    <= 0;
            m_halt <= 1'b0;
        end else if (m_halt) begin
            m_t <= 0;
        end else if (tb_adv) begin
            if (m_t == 2 && ir_op == 4'hF) begin
                m_halt <= 1'b1;
                m_t    <= 0;
            end else if (m_t >= last_t(ir_op)) begin
                m_t <= 0;
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [14:0] e;
        e = (!rstn || m_halt) ? 15'd0 : exp_ctrl(m_t, ir_op, flag_c, flag_z, tb_adv);
        chk("cyc_tstate", 32'(tstate), 32'(m_t));
        chk("cyc_halt", 32'(halt), 32'(m_halt));
        chk("cyc_ctrl", 32'(ctrl), 32'(e));
        chk("bus_oe_onehot", 32'($countones(ctrl & OE_MASK) <= 1), 32'd1);
    end

    task automatic run(input logic [3:0] op, input logic fc, input logic fz);
        ir_op = op; flag_c = fc; flag_z = fz;
        repeat (last_t(op) + 1) @(posedge clk);
        #1;
        chk("instr_end_t0", 32'(tstate), 32'd0);
        $display("instr op=%0h fc=%0d fz=%0d tstate=%0d", op, fc, fz, tstate);
    endtask

    task automatic jtest(input logic [3:0] op, input logic fc, input logic fz, input logic exp);
        ir_op = op; flag_c = fc; flag_z = fz;
        repeat (3) @(negedge clk);
        chk("jmp_t2_ir_oe", 32'(ir_oe), 32'd1);
        chk("jmp_t2_pc_we", 32'(pc_we), 32'(exp));
        @(posedge clk); #1;
        chk("jmp_next_t0", 32'(tstate), 32'd0);
        $display("jump op=%0h fc=%0d fz=%0d pc_we=%0d", op, fc, fz, exp);
    endtask

    initial begin
        rstn = 1'b0; ir_op = 4'd0; flag_c = 1'b0; flag_z = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tstate", 32'(tstate), 32'd0);
        chk("rst_ctrl", 32'(ctrl), 32'd0);

        // Fetch then ADD, then SUB
        @(posedge clk); #1 rstn = 1'b1; ir_op = 4'd2;
        @(negedge clk);
        chk("t0_pc_oe", 32'(pc_oe), 32'd1);
        chk("t0_mar_we", 32'(mar_we), 32'd1);
        @(negedge clk);
        chk("t1_ctrl", 32'(ctrl), 32'(RAM_OE | IR_WE | PC_INC));
        @(negedge clk);
        chk("add_t2", 32'(ctrl), 32'(IR_OE | MAR_WE));
        @(negedge clk);
        chk("add_t3", 32'(ctrl), 32'(RAM_OE | B_WE));
        @(negedge clk);
        chk("add_t4", 32'(ctrl), 32'(ALU_OE | A_WE | FLAGS_WE));
        @(posedge clk); #1;
        chk("add_wrap_t0", 32'(tstate), 32'd0);
        $display("instr op=2 ADD checked");
        ir_op = 4'd3;
        repeat (4) @(negedge clk);
        chk("sub_t3_alu_sub", 32'(alu_sub), 32'd0);
        @(negedge clk);
        chk("sub_t4_alu_sub", 32'(alu_sub), 32'd1);
        @(posedge clk); #1;
        chk("sub_wrap_t0", 32'(tstate), 32'd0);
        $display("instr op=3 SUB checked");

        jtest(4'd7, 1'b0, 1'b1, 1'b0);
        jtest(4'd7, 1'b1, 1'b0, 1'b1);
        jtest(4'd8, 1'b1, 1'b0, 1'b0);
        jtest(4'd8, 1'b0, 1'b1, 1'b1);

        // Halt and recovery
        ir_op = 4'hF;
        repeat (3) @(posedge clk); #1;
        chk("hlt_halt", 32'(halt), 32'd1);
        repeat (20) begin
            @(negedge clk);
            chk("hlt_tstate", 32'(tstate), 32'd0);
            chk("hlt_ctrl", 32'(ctrl), 32'd0);
        end
        @(posedge clk); #1 rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1; ir_op = 4'd0;
        chk("hlt_cleared", 32'(halt), 32'd0);
        @(negedge clk);
        chk("resume_t0", 32'(ctrl), 32'(PC_OE | MAR_WE));
        $display("instr op=F HLT checked");

        // Asynchronous reset in T3 of ADD
        ir_op = 4'd2;
        repeat (3) @(posedge clk);
        #2;
        chk("async_pre_b_we", 32'(b_we), 32'd1);
        rstn = 1'b0;
        #1;
        chk("async_ctrl", 32'(ctrl), 32'd0);
        chk("async_tstate", 32'(tstate), 32'd0);
        @(posedge clk); #1 rstn = 1'b1;
        $display("async reset mid-ADD checked");

        for (int op = 0; op < 15; op++)
            run(4'(op), op[0], op[1]);
        for (int op = 0; op < 15; op++)
            run(4'(op), ~op[0], ~op[1]);

`ifdef SINGLE_STEP_EN
        ir_op = 4'd1;
        @(posedge clk); #1 step_mode = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("step_hold_t", 32'(tstate), 32'd1);
            chk("step_hold_ctrl", 32'(ctrl), 32'(RAM_OE));
        end
        @(posedge clk); #1 step = 1'b1;
        @(negedge clk);
        chk("step_pulse_ctrl", 32'(ctrl), 32'(RAM_OE | IR_WE | PC_INC));
        @(posedge clk); #1 step = 1'b0; step_mode = 1'b0;
        chk("step_adv_t2", 32'(tstate), 32'd2);
        repeat (2) @(posedge clk); #1;
        chk("step_end_t0", 32'(tstate), 32'd0);
        $display("single-step LDA checked");
`endif

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
